// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_IF_WAIT  = 4'd2,
        ST_DECODE   = 4'd3,
        ST_EXEC     = 4'd4,
        ST_MEM      = 4'd5,
        ST_MEM_WAIT = 4'd6,
        ST_WB       = 4'd7,
        ST_TRAP     = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDR = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        CAUSE_NONE        = 2'd0,
        CAUSE_ILLEGAL     = 2'd1,
        CAUSE_MEM_TIMEOUT = 2'd2
    } trap_cause_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // Only word loads/stores and BEQ/BNE are implemented; other funct3 values trap.
    function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (opc)
            OP_R, OP_IMM, OP_JAL, OP_LUI: ok = 1'b1;
            OP_LOAD, OP_STORE:            ok = (f3 == F3_WORD);
            OP_BRANCH:                    ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Branch decision from the ALU compare (ALU computes rs1 - rs2).
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return ((f3 == F3_BEQ) && zero) || ((f3 == F3_BNE) && !zero);
    endfunction

endpackage

// File: rtl/mc_wdog.sv
// Memory stall watchdog: counts cycles spent waiting on a handshake and
// flags expiry on the last allowed cycle. MEM_TIMEOUT = 0 disables it.
module mc_wdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic WDOG_ON = (MEM_TIMEOUT > 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is only meaningful while actually waiting.
    assign expired = WDOG_ON && count_en && (count_q == LIMIT);

    // Clear on any state change, otherwise count up while waiting (saturating at the limit).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (WDOG_ON && count_en && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// over a shared datapath with a single req/gnt/rvalid memory port.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        alu_zero,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    output logic        pc_we,
    output logic        pc_src,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        rf_we,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic [31:0] retire_cnt,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state_o
);

    state_e      state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    wb_sel_e     wb_sel_c;
    logic        wdog_clear;
    logic        wdog_count_en;
    logic        wdog_expired;

    // Watchdog only runs in states that wait on the memory handshake.
    assign wdog_count_en = (state_q == ST_FETCH) || (state_q == ST_IF_WAIT) ||
                           (state_q == ST_MEM)   || (state_q == ST_MEM_WAIT);
    assign wdog_clear    = (state_d != state_q);

    mc_wdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wdog_clear),
        .count_en (wdog_count_en),
        .expired  (wdog_expired)
    );

    // Next-state and control outputs; a handshake always beats watchdog expiry.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        rf_we     = 1'b0;
        alu_src_b = 1'b0;
        wb_sel_c  = WB_ALU;
        retire    = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = ST_IF_WAIT;
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_IF_WAIT: begin
                if (mem_rvalid) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode, funct3)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_src_b = 1'b0;
                        state_d   = ST_WB;
                    end
                    OP_IMM: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_LUI: begin
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_b = 1'b0;
                        pc_we     = 1'b1;
                        pc_src    = branch_taken(funct3, alu_zero);
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    OP_JAL: begin
                        rf_we    = 1'b1;
                        wb_sel_c = WB_PC4;
                        pc_we    = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: begin
                        // Unreachable after DECODE, but never execute garbage.
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_sel   = 1'b1;
                mem_we    = (opcode == OP_STORE);
                alu_src_b = 1'b1;
                if (mem_gnt) begin
                    if (opcode == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rvalid) begin
                    mdr_we  = 1'b1;
                    state_d = ST_WB;
                end else if (wdog_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_MEM_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                alu_src_b = (opcode == OP_IMM);
                if (opcode == OP_LOAD) begin
                    wb_sel_c = WB_MDR;
                end else if (opcode == OP_LUI) begin
                    wb_sel_c = WB_IMM;
                end else begin
                    wb_sel_c = WB_ALU;
                end
                pc_we   = 1'b1;
                pc_src  = 1'b0;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // State, trap cause and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            cause_q      <= CAUSE_NONE;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign wb_sel     = wb_sel_c;
    assign retire_cnt = retire_cnt_q;
    assign trap       = (state_q == ST_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;

endmodule
